// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   DMEM_ADDR_W / DMEM_DATA_W : default address / word widths
//   dm_state_e                : responder FSM encoding (INIT clears, RUN serves)
//   WM_READ_FIRST / WM_WRITE_FIRST : douta behaviour on a write access
package dmem_pkg;
  localparam int DMEM_ADDR_W = 7;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic {
    DM_INIT = 1'b0,
    DM_RUN  = 1'b1
  } dm_state_e;

  localparam int WM_READ_FIRST  = 0;
  localparam int WM_WRITE_FIRST = 1;
endpackage

// File: rtl/dmem_sat_counter.sv
// 16-bit saturating event counter.
//   clk   : clock, rising edge
//   clr   : synchronous clear (dominates inc)
//   inc   : count one event this edge
//   count : current value, sticks at 16'hFFFF
module dmem_sat_counter (
  input  logic        clk,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);
  always_ff @(posedge clk) begin
    if (clr)                          count <= '0;
    else if (inc && count != 16'hFFFF) count <= count + 16'd1;
  end
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: DEPTH x DATA_W synchronous single-port RAM with a
// self-clearing init phase after every reset. Drop-in for the vendor BRAM.
//   clka  : clock            rsta  : sync active-high reset
//   ena   : access enable    wea   : write enable (qualified by ena)
//   addra : word address     dina  : write data
//   douta : read data, READ_LATENCY (1|2) edges after the access
//   ready : array cleared, accesses honoured
// Optional build macro DMEM_STATS_EN adds rd_count / wr_count, 16-bit
// saturating counts of RUN-state reads and writes.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_W       = DMEM_ADDR_W,
  parameter int          DATA_W       = DMEM_DATA_W,
  parameter int          READ_LATENCY = 1,
  parameter int          WRITE_MODE   = WM_READ_FIRST,
  parameter logic [31:0] INIT_VALUE   = 32'h0
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
`ifdef DMEM_STATS_EN
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
`endif
  output logic              ready
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  dm_state_e         state, state_d;
  logic [ADDR_W-1:0] init_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              rd_en;
  logic [DATA_W-1:0] rd1;

  // state is a register, so ready rises on the same edge the last init
  // word is written and falls on the reset edge.
  assign ready = (state == DM_RUN);

  always_ff @(posedge clka) begin
    if (rsta) begin
      state     <= DM_INIT;
      init_addr <= '0;
    end else begin
      state <= state_d;
      if (state == DM_INIT) init_addr <= init_addr + 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    mem_we  = 1'b0;
    mem_wa  = addra;
    mem_wd  = dina;
    rd_en   = 1'b0;
    case (state)
      DM_INIT: begin
        mem_we = 1'b1;
        mem_wa = init_addr;
        mem_wd = INIT_VALUE[DATA_W-1:0];
        if (init_addr == {ADDR_W{1'b1}}) state_d = DM_RUN;
      end
      DM_RUN: begin
        mem_we = ena & wea;
        rd_en  = ena;
      end
      default: state_d = DM_INIT;
    endcase
    // Reset beats any write landing on the same edge.
    if (rsta) mem_we = 1'b0;
  end

  // Array has no reset so it maps onto block RAM; INIT does the clearing.
  always_ff @(posedge clka) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Stage-1 read register; mem[addra] here is the pre-write word, which
  // gives READ_FIRST for free.
  always_ff @(posedge clka) begin
    if (rsta) rd1 <= '0;
    else if (rd_en)
      rd1 <= (wea && WRITE_MODE == WM_WRITE_FIRST) ? dina : mem[addra];
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_W-1:0] rd2;
      always_ff @(posedge clka) begin
        if (rsta) rd2 <= '0;
        else      rd2 <= rd1;
      end
      assign douta = rd2;
    end else begin : g_lat1
      assign douta = rd1;
    end
  endgenerate

`ifdef DMEM_STATS_EN
  dmem_sat_counter u_rd_cnt (
    .clk   (clka),
    .clr   (rsta),
    .inc   (ready & ena & ~wea),
    .count (rd_count)
  );
  dmem_sat_counter u_wr_cnt (
    .clk   (clka),
    .clr   (rsta),
    .inc   (ready & ena & wea),
    .count (wr_count)
  );
`endif
endmodule
